// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_unit
// Description : PC + synchronous imem reader feeding decode through a 2-entry
//               queue with valid/ready handshake; flushes on branch redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int RESET_PC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fetch_en,
    output logic                  imem_rd_en,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    output logic [31:0]           instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  branch,
    input  logic                  branch_abs,
    input  logic [31:0]           branch_offset,
    input  logic [ADDR_WIDTH-1:0] branch_pc
);

    localparam logic [1:0] c_st_boot = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_idle = 2'd2;

    localparam logic [ADDR_WIDTH-1:0] c_reset_pc = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] c_one      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_tag;
    logic                  r_inflight;
    logic [1:0]            r_count;
    logic [31:0]           r_q_data [2];
    logic [ADDR_WIDTH-1:0] r_q_pc   [2];

    logic                  w_pop;
    logic                  w_push;
    logic                  w_redirect;
    logic                  w_issue;
    logic [2:0]            w_occ;
    logic [ADDR_WIDTH-1:0] w_target;
    logic                  w_unused;

    assign w_unused   = &{1'b0, branch_offset[31:ADDR_WIDTH]};

    assign w_pop      = (r_count != 2'd0) && instr_ready;
    assign w_redirect = branch && (r_state != c_st_boot);
    // A response landing in the redirect cycle belongs to the old path.
    assign w_push     = r_inflight && !w_redirect;
    assign w_occ      = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = (r_state == c_st_run) && fetch_en && !branch && (w_occ < 3'd2);
    assign w_target   = branch_abs ? branch_offset[ADDR_WIDTH-1:0]
                                   : branch_pc + c_one + branch_offset[ADDR_WIDTH-1:0];

    assign imem_rd_en  = w_issue;
    assign imem_addr   = r_pc;
    assign instr_out   = r_q_data[0];
    assign instr_pc    = r_q_pc[0];
    assign instr_valid = (r_count != 2'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_boot;
            r_pc        <= c_reset_pc;
            r_tag       <= '0;
            r_inflight  <= 1'b0;
            r_count     <= 2'd0;
            r_q_data[0] <= '0;
            r_q_data[1] <= '0;
            r_q_pc[0]   <= '0;
            r_q_pc[1]   <= '0;
        end else begin
            case (r_state)
                c_st_boot: r_state <= fetch_en ? c_st_run : c_st_idle;
                c_st_run:  if (!fetch_en) r_state <= c_st_idle;
                c_st_idle: if (fetch_en) r_state <= c_st_run;
                default:   r_state <= c_st_boot;
            endcase

            if (w_redirect) begin
                r_pc       <= w_target;
                r_inflight <= 1'b0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_pc  <= r_pc + c_one;
                    r_tag <= r_pc;
                end
            end

            if (w_redirect) begin
                r_count <= 2'd0;
            end else begin
                case ({w_push, w_pop})
                    2'b11: begin
                        if (r_count == 2'd2) begin
                            r_q_data[0] <= r_q_data[1];
                            r_q_pc[0]   <= r_q_pc[1];
                            r_q_data[1] <= imem_rdata;
                            r_q_pc[1]   <= r_tag;
                        end else begin
                            r_q_data[0] <= imem_rdata;
                            r_q_pc[0]   <= r_tag;
                        end
                    end
                    2'b10: begin
                        // Issue rule keeps count below 2 whenever a push arrives.
                        r_q_data[r_count[0]] <= imem_rdata;
                        r_q_pc[r_count[0]]   <= r_tag;
                        r_count              <= r_count + 2'd1;
                    end
                    2'b01: begin
                        r_q_data[0] <= r_q_data[1];
                        r_q_pc[0]   <= r_q_pc[1];
                        r_count     <= r_count - 2'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch_unit
// Description : Scoreboard bench; expected fetch stream is a PC sequence that
//               restarts at each branch target or reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch_unit;

    localparam int AW     = 10;
    localparam int DEPTH  = 1 << AW;
    localparam int RST_PC = 0;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fetch_en = 1'b0;
    logic          imem_rd_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata = '0;
    logic [31:0]   instr_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          branch = 1'b0;
    logic          branch_abs = 1'b0;
    logic [31:0]   branch_offset = '0;
    logic [AW-1:0] branch_pc = '0;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] exp_q [$];
    logic [AW-1:0] mon_e;
    int            next_pc = RST_PC;
    int            br_tgt = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            pops = 0;
    int            cyc = 0;
    int            first_rd;
    int            first_v;

    instruction_fetch_unit #(.ADDR_WIDTH(AW), .RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_en      (fetch_en),
        .imem_rd_en    (imem_rd_en),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr_out     (instr_out),
        .instr_pc      (instr_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .branch        (branch),
        .branch_abs    (branch_abs),
        .branch_offset (branch_offset),
        .branch_pc     (branch_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (imem_rd_en) imem_rdata <= mem[imem_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(AW'(next_pc));
            next_pc = (next_pc + 1) % DEPTH;
        end
    endfunction

    // Monitor: every accepted word must be the next PC on the current path.
    always @(negedge clk) begin
        if (!rst) begin
            if (instr_valid && instr_ready) begin
                pops++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: got pc %0h expected none", instr_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("instr_pc", 32'(instr_pc), 32'(mon_e));
                    check("instr_out", instr_out, mem[mon_e]);
                    refill();
                end
            end
            if (branch && cyc != 0) begin
                check("rd_en_in_branch", 32'(imem_rd_en), 32'd0);
                exp_q.delete();
                next_pc = br_tgt;
                refill();
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst    = 1'b1;
        branch = 1'b0;
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_out", instr_out, 32'd0);
        check("rst_pc", 32'(instr_pc), 32'd0);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'(RST_PC));
        exp_q.delete();
        next_pc = RST_PC;
        refill();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic startup_timing();
        first_rd = -1;
        first_v  = -1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (imem_rd_en && first_rd < 0) first_rd = cyc;
            if (instr_valid && first_v < 0) first_v = cyc;
        end
        check("first_rd_cycle", 32'(first_rd), 32'd1);
        check("first_valid_cycle", 32'(first_v), 32'd3);
    endtask

    // Caller is just after a rising edge; branch held for exactly one cycle.
    task automatic branch_to(input bit abs, input int bpc, input logic [31:0] off);
        br_tgt        = abs ? int'(off % 32'(DEPTH)) : (bpc + 1 + int'(off % 32'(DEPTH))) % DEPTH;
        branch_abs    = abs;
        branch_pc     = AW'(bpc);
        branch_offset = off;
        branch        = 1'b1;
        @(posedge clk);
        #1;
        branch = 1'b0;
    endtask

    task automatic branch_latency(input int tgt);
        @(negedge clk);
        check("br_gap1_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("br_gap2_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        check("br_tgt_valid", 32'(instr_valid), 32'd1);
        check("br_tgt_pc", 32'(instr_pc), 32'(tgt));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        fetch_en    = 1'b1;
        instr_ready = 1'b1;
        do_reset();
        startup_timing();

        // Back-pressure until the queue fills.
        @(posedge clk); #1;
        instr_ready = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("full_no_issue", 32'(imem_rd_en), 32'd0);
        check("full_valid", 32'(instr_valid), 32'd1);
        @(posedge clk); #1;
        instr_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        branch_to(1'b0, 5, 32'd3);
        branch_latency(9);
        branch_to(1'b1, 0, 32'h20);
        branch_latency(32'h20);
        branch_to(1'b0, 100, 32'hFFFF_FC03);
        branch_latency(104);

        // Address wrap, sequential and relative.
        branch_to(1'b1, 0, 32'd1022);
        repeat (8) @(posedge clk);
        #1;
        branch_to(1'b0, 1020, 32'd5);
        branch_latency(2);

        // Branch while the queue is full and stalled.
        instr_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        branch_to(1'b1, 0, 32'd7);
        branch_latency(7);
        instr_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Stop issuing; queue drains.
        fetch_en = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("drain_valid", 32'(instr_valid), 32'd0);
        check("drain_rd_en", 32'(imem_rd_en), 32'd0);
        @(posedge clk); #1;
        branch_to(1'b1, 0, 32'd300);
        repeat (3) @(posedge clk);
        #1;
        fetch_en = 1'b1;
        repeat (6) @(posedge clk);

        do_reset();
        startup_timing();

        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            instr_ready = ($urandom_range(0, 3) != 0);
            fetch_en    = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 15) == 0) begin
                branch_abs    = $urandom_range(0, 1) != 0;
                branch_pc     = AW'($urandom_range(0, DEPTH - 1));
                branch_offset = $urandom;
                br_tgt        = branch_abs ? int'(branch_offset % 32'(DEPTH))
                                           : (int'(branch_pc) + 1 + int'(branch_offset % 32'(DEPTH))) % DEPTH;
                branch        = 1'b1;
            end else begin
                branch = 1'b0;
            end
            if (i % 1000 == 999) begin
                fetch_en    = 1'b1;
                instr_ready = 1'b1;
                do_reset();
            end
        end
        @(posedge clk); #1;
        branch = 1'b0;
        repeat (4) @(posedge clk);

        check("stream_progress", 32'(pops > 300), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
